// File: rtl/register_array_pq_kv.sv
// Register-array priority queue of key/value pairs. Entries are held best-first,
// so entry 0 is always the head; one push, pop or replace is accepted per cycle.
module register_array_pq_kv #(
  parameter int QUEUE_SIZE = 8,
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 16,
  parameter bit MAX_FIRST  = 1'b1
) (
  input  logic                        i_CLK,
  input  logic                        i_RSTn,
  input  logic                        i_wrt,
  input  logic                        i_read,
  input  logic                        i_flush,
  input  logic [KEY_WIDTH-1:0]        i_key,
  input  logic [VAL_WIDTH-1:0]        i_val,
  input  logic                        i_clr_err,
  output logic [KEY_WIDTH-1:0]        o_key,
  output logic [VAL_WIDTH-1:0]        o_val,
  output logic                        o_valid,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(QUEUE_SIZE):0] o_size,
  output logic                        o_ovf,
  output logic                        o_udf
);

  localparam int SW = $clog2(QUEUE_SIZE) + 1;

  typedef struct packed {
    logic                 valid;
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } entry_t;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_REPL,
    OP_PUSH,
    OP_POP
  } op_e;

  entry_t                q      [QUEUE_SIZE];
  entry_t                base   [QUEUE_SIZE];
  entry_t                q_next [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] gt;
  logic [SW-1:0]         size_q;
  logic [SW-1:0]         size_next;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  full;
  logic                  empty;
  logic                  do_remove;
  logic                  do_insert;
  op_e                   op;
  entry_t                new_e;

  // Invalid slots rank below every valid entry, whatever the ordering mode.
  function automatic logic ranks_above(input logic [KEY_WIDTH-1:0] new_key,
                                       input logic                 b_valid,
                                       input logic [KEY_WIDTH-1:0] b_key);
    if (!b_valid) return 1'b1;
    return MAX_FIRST ? (new_key > b_key) : (new_key < b_key);
  endfunction

  assign full  = (size_q == SW'(QUEUE_SIZE));
  assign empty = (size_q == '0);
  assign new_e = '{valid: 1'b1, key: i_key, val: i_val};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op = OP_IDLE;
    if (i_flush)              op = OP_FLUSH;
    else if (i_wrt && i_read) op = OP_REPL;
    else if (i_wrt)           op = OP_PUSH;
    else if (i_read)          op = OP_POP;
  end

  assign do_remove = ((op == OP_POP) || (op == OP_REPL)) && !empty;
  assign do_insert = ((op == OP_PUSH) && !full) || (op == OP_REPL);

  // Removing the head is a shift toward entry 0; the tail slot becomes empty.
  always_comb begin
    for (int i = 0; i < QUEUE_SIZE - 1; i++)
      base[i] = do_remove ? q[i+1] : q[i];
    base[QUEUE_SIZE-1] = do_remove ? '0 : q[QUEUE_SIZE-1];
  end

  // One parallel compare stage: gt is monotone over a best-first array, so the
  // new entry lands at its first 0->1 edge and everything after shifts down.
  // Strict compare places a new key behind equal keys; pairs move as a unit.
  always_comb begin
    for (int i = 0; i < QUEUE_SIZE; i++)
      gt[i] = ranks_above(i_key, base[i].valid, base[i].key);
  end

  always_comb begin
    q_next[0] = (do_insert && gt[0]) ? new_e : base[0];
    for (int i = 1; i < QUEUE_SIZE; i++) begin
      if (do_insert && gt[i]) q_next[i] = gt[i-1] ? base[i-1] : new_e;
      else                    q_next[i] = base[i];
    end
    if (op == OP_FLUSH) begin
      for (int i = 0; i < QUEUE_SIZE; i++) q_next[i].valid = 1'b0;
    end
  end

  always_comb begin
    size_next = size_q;
    case (op)
      OP_FLUSH: size_next = '0;
      OP_PUSH:  if (!full)  size_next = size_q + SW'(1);
      OP_POP:   if (!empty) size_next = size_q - SW'(1);
      OP_REPL:  if (empty)  size_next = SW'(1);
      default:  ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      // NOTE: the whole array is reset because zeroed keys/values are part of the reset state.
      for (int i = 0; i < QUEUE_SIZE; i++) q[i] <= '0;
      size_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) q[i] <= q_next[i];
      size_q <= size_next;
      // NOTE: non-blocking only; the later set deliberately wins over a same-cycle clear.
      if (i_clr_err) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end
      if ((op == OP_PUSH) && full) ovf_q <= 1'b1;
      if ((op == OP_POP) && empty) udf_q <= 1'b1;
    end
  end

  // Head is masked when empty so stale register contents never leak out.
  assign o_key   = empty ? '0 : q[0].key;
  assign o_val   = empty ? '0 : q[0].val;
  assign o_valid = !empty;
  assign o_empty = empty;
  assign o_full  = full;
  assign o_size  = size_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

endmodule

// File: tb/tb_register_array_pq_kv.sv
// Bench for register_array_pq_kv: a max-first and a min-first instance share
// stimulus and are compared against an unsorted-bag reference model.
module tb_register_array_pq_kv;

  localparam int QS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0, rd = 1'b0, flush = 1'b0, clr = 1'b0;
  logic [15:0] key = '0, val = '0;

  logic [15:0] o_key   [2];
  logic [15:0] o_val   [2];
  logic        o_valid [2];
  logic        o_full  [2];
  logic        o_empty [2];
  logic        o_ovf   [2];
  logic        o_udf   [2];
  logic [3:0]  o_size  [2];

  int total = 0;
  int bad   = 0;

  // Model: index 0 follows the max-first DUT, index 1 the min-first DUT.
  logic [15:0] mkey [2][QS];
  logic [15:0] mval [2][QS];
  int          mcnt [2] = '{0, 0};
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;

  always #5 clk = ~clk;

  register_array_pq_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(16), .VAL_WIDTH(16), .MAX_FIRST(1'b1)) dut_max (
    .i_CLK(clk), .i_RSTn(rst_n), .i_wrt(wrt), .i_read(rd), .i_flush(flush),
    .i_key(key), .i_val(val), .i_clr_err(clr),
    .o_key(o_key[0]), .o_val(o_val[0]), .o_valid(o_valid[0]), .o_full(o_full[0]),
    .o_empty(o_empty[0]), .o_size(o_size[0]), .o_ovf(o_ovf[0]), .o_udf(o_udf[0])
  );

  register_array_pq_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(16), .VAL_WIDTH(16), .MAX_FIRST(1'b0)) dut_min (
    .i_CLK(clk), .i_RSTn(rst_n), .i_wrt(wrt), .i_read(rd), .i_flush(flush),
    .i_key(key), .i_val(val), .i_clr_err(clr),
    .o_key(o_key[1]), .o_val(o_val[1]), .o_valid(o_valid[1]), .o_full(o_full[1]),
    .o_empty(o_empty[1]), .o_size(o_size[1]), .o_ovf(o_ovf[1]), .o_udf(o_udf[1])
  );

  function automatic int best_idx(int m);
    int b = -1;
    for (int i = 0; i < mcnt[m]; i++)
      if (b < 0 || (m == 0 ? mkey[m][i] > mkey[m][b] : mkey[m][i] < mkey[m][b])) b = i;
    return b;
  endfunction

  task automatic m_insert(int m, logic [15:0] k, logic [15:0] v);
    mkey[m][mcnt[m]] = k;
    mval[m][mcnt[m]] = v;
    mcnt[m]++;
  endtask

  task automatic m_remove(int m);
    int b = best_idx(m);
    mkey[m][b] = mkey[m][mcnt[m]-1];
    mval[m][b] = mval[m][mcnt[m]-1];
    mcnt[m]--;
  endtask

  task automatic model_apply(bit w, bit r, bit f, bit c, logic [15:0] k, logic [15:0] v);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    for (int m = 0; m < 2; m++) begin
      if (f) mcnt[m] = 0;
      else if (w && r) begin
        if (mcnt[m] > 0) m_remove(m);
        m_insert(m, k, v);
      end else if (w) begin
        if (mcnt[m] == QS) m_ovf = 1'b1;
        else m_insert(m, k, v);
      end else if (r) begin
        if (mcnt[m] == 0) m_udf = 1'b1;
        else m_remove(m);
      end
    end
  endtask

  function automatic logic [31:0] exp_head(int m);
    int b = best_idx(m);
    return (b < 0) ? 32'h0 : {mkey[m][b], mval[m][b]};
  endfunction

  // Status vector: {size, empty, full, valid, ovf, udf}.
  function automatic logic [8:0] exp_stat(int m);
    int n = mcnt[m];
    return {4'(n), n == 0, n == QS, n != 0, m_ovf, m_udf};
  endfunction

  function automatic logic [8:0] obs_stat(int m);
    return {o_size[m], o_empty[m], o_full[m], o_valid[m], o_ovf[m], o_udf[m]};
  endfunction

  task automatic step(bit w, bit r, bit f, bit c, logic [15:0] k, logic [15:0] v);
    @(negedge clk);
    wrt = w; rd = r; flush = f; clr = c; key = k; val = v;
    @(posedge clk);
    model_apply(w, r, f, c, k, v);
    #1;
    wrt = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
  endtask

  task automatic push(logic [15:0] k, logic [15:0] v); step(1, 0, 0, 0, k, v); endtask
  task automatic pop();                                step(0, 1, 0, 0, '0, '0); endtask
  task automatic do_flush();                           step(0, 0, 1, 1, '0, '0); endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs_stat(m) !== {4'd0, 5'b10000}) begin
        bad++; $display("FAIL reset_stat[%0d] got %b want %b", m, obs_stat(m), {4'd0, 5'b10000});
      end
      total++;
      if ({o_key[m], o_val[m]} !== 32'h0) begin
        bad++; $display("FAIL reset_head[%0d] got %h want 0", m, {o_key[m], o_val[m]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_push_pop();
    logic [15:0] ek [4] = '{16'd9, 16'd5, 16'd3, 16'd0};
    logic [15:0] ev [4] = '{16'hA9, 16'hA5, 16'hA3, 16'hA0};
    push(16'd5, 16'hA5); push(16'd9, 16'hA9); push(16'd0, 16'hA0); push(16'd3, 16'hA3);
    total++;
    if (o_size[0] !== 4'd4) begin bad++; $display("FAIL pp_size got %0d want 4", o_size[0]); end
    total++;
    if ({o_key[1], o_val[1]} !== {16'd0, 16'hA0}) begin
      bad++; $display("FAIL pp_min_head got %h want %h", {o_key[1], o_val[1]}, {16'd0, 16'hA0});
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({o_key[0], o_val[0]} !== {ek[i], ev[i]}) begin
        bad++; $display("FAIL pp_head%0d got %h want %h", i, {o_key[0], o_val[0]}, {ek[i], ev[i]});
      end
      pop();
    end
    total++;
    if (o_empty[0] !== 1'b1 || o_key[0] !== 16'd0 || o_val[0] !== 16'd0) begin
      bad++; $display("FAIL pp_drained got empty=%b key=%h val=%h want 1/0/0", o_empty[0], o_key[0], o_val[0]);
    end
  endtask

  task automatic test_overflow();
    do_flush();
    for (int k = 1; k <= 8; k++) push(16'(k), 16'(16'h100 + k));
    push(16'd100, 16'h1FF);
    total++;
    if ({o_full[0], o_ovf[0], o_size[0]} !== {1'b1, 1'b1, 4'd8} || o_key[0] !== 16'd8) begin
      bad++; $display("FAIL ovf_max got full=%b ovf=%b size=%0d key=%0d want 1/1/8/8",
                      o_full[0], o_ovf[0], o_size[0], o_key[0]);
    end
    total++;
    if (o_key[1] !== 16'd1 || o_ovf[1] !== 1'b1) begin
      bad++; $display("FAIL ovf_min got key=%0d ovf=%b want 1/1", o_key[1], o_ovf[1]);
    end
    step(0, 0, 0, 1, '0, '0);
    total++;
    if (o_ovf[0] !== 1'b0 || o_full[0] !== 1'b1) begin
      bad++; $display("FAIL ovf_clear got ovf=%b full=%b want 0/1", o_ovf[0], o_full[0]);
    end
  endtask

  task automatic test_underflow();
    do_flush();
    pop();
    total++;
    if (o_udf[0] !== 1'b1 || o_size[0] !== 4'd0) begin
      bad++; $display("FAIL udf_set got udf=%b size=%0d want 1/0", o_udf[0], o_size[0]);
    end
    push(16'd7, 16'h77);
    total++;
    if ({o_valid[0], o_udf[0]} !== 2'b11 || {o_key[0], o_val[0]} !== {16'd7, 16'h77}) begin
      bad++; $display("FAIL udf_hold got valid=%b udf=%b head=%h want 1/1/00070077",
                      o_valid[0], o_udf[0], {o_key[0], o_val[0]});
    end
  endtask

  task automatic test_replace();
    do_flush();
    push(16'd4, 16'h40); push(16'd6, 16'h60); push(16'd2, 16'h20);
    step(1, 1, 0, 0, 16'd5, 16'h50);
    total++;
    if ({o_key[0], o_val[0]} !== {16'd5, 16'h50} || o_size[0] !== 4'd3) begin
      bad++; $display("FAIL repl1_max got head=%h size=%0d want 00050050/3", {o_key[0], o_val[0]}, o_size[0]);
    end
    total++;
    if ({o_key[1], o_val[1]} !== {16'd4, 16'h40}) begin
      bad++; $display("FAIL repl1_min got %h want 00040040", {o_key[1], o_val[1]});
    end
    step(1, 1, 0, 0, 16'd1, 16'h10);
    total++;
    if ({o_key[0], o_val[0]} !== {16'd4, 16'h40} || {o_key[1], o_val[1]} !== {16'd1, 16'h10}) begin
      bad++; $display("FAIL repl2 got max=%h min=%h want 00040040/00010010", {o_key[0], o_val[0]}, {o_key[1], o_val[1]});
    end
    do_flush();
    step(1, 1, 0, 0, 16'd9, 16'h90);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs_stat(m) !== {4'd1, 5'b00100} || {o_key[m], o_val[m]} !== {16'd9, 16'h90}) begin
        bad++; $display("FAIL repl_empty[%0d] got stat=%b head=%h want %b/00090090",
                        m, obs_stat(m), {o_key[m], o_val[m]}, {4'd1, 5'b00100});
      end
    end
  endtask

  task automatic test_min_first();
    logic [15:0] mn [3] = '{16'd10, 16'd20, 16'd30};
    do_flush();
    push(16'd30, 16'h3); push(16'd10, 16'h1); push(16'd20, 16'h2);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o_key[1] !== mn[i] || o_key[0] !== mn[2-i]) begin
        bad++; $display("FAIL order%0d got min=%0d max=%0d want %0d/%0d", i, o_key[1], o_key[0], mn[i], mn[2-i]);
      end
      pop();
    end
    total++;
    if (o_empty[1] !== 1'b1) begin bad++; $display("FAIL order_empty got %b want 1", o_empty[1]); end
  endtask

  task automatic test_flush();
    pop();
    push(16'd11, 16'h1); push(16'd12, 16'h2); push(16'd13, 16'h3);
    step(1, 0, 1, 0, 16'd77, 16'h77);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs_stat(m) !== {4'd0, 5'b10001} || {o_key[m], o_val[m]} !== 32'h0) begin
        bad++; $display("FAIL flush[%0d] got stat=%b head=%h want %b/0", m, obs_stat(m),
                        {o_key[m], o_val[m]}, {4'd0, 5'b10001});
      end
    end
  endtask

  task automatic test_ties();
    logic [15:0] first;
    do_flush();
    push(16'd5, 16'h11); push(16'd5, 16'h22);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (o_key[m] !== 16'd5 || !(o_val[m] === 16'h11 || o_val[m] === 16'h22)) begin
        bad++; $display("FAIL tie_first[%0d] got %h want key 5 with val 11 or 22", m, {o_key[m], o_val[m]});
      end
    end
    first = o_val[0];
    pop();
    total++;
    if (o_key[0] !== 16'd5 || o_val[0] !== (first ^ 16'h33) || o_size[0] !== 4'd1) begin
      bad++; $display("FAIL tie_second got %h size=%0d want %h size=1", {o_key[0], o_val[0]}, o_size[0],
                      {16'd5, first ^ 16'h33});
    end
    do_flush();
  endtask

  function automatic bit key_stored(logic [15:0] k);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < mcnt[m]; i++)
        if (mkey[m][i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_random();
    bit w, r, f, c;
    logic [15:0] k, v;
    do_flush();
    for (int cyc = 0; cyc < 400; cyc++) begin
      w = ($urandom_range(0, 99) < 50);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      c = ($urandom_range(0, 99) < 8);
      v = 16'($urandom);
      k = 16'($urandom_range(0, 31));
      for (int t = 0; t < 64 && key_stored(k); t++) k = 16'($urandom_range(0, 31));
      step(w, r, f, c, k, v);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs_stat(m) !== exp_stat(m)) begin
          bad++; $display("FAIL rand_stat[%0d] cyc %0d got %b want %b", m, cyc, obs_stat(m), exp_stat(m));
        end
        total++;
        if ({o_key[m], o_val[m]} !== exp_head(m)) begin
          bad++; $display("FAIL rand_head[%0d] cyc %0d got %h want %h", m, cyc, {o_key[m], o_val[m]}, exp_head(m));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    pop();
    push(16'd12, 16'hC); push(16'd13, 16'hD);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    mcnt[0] = 0; mcnt[1] = 0; m_ovf = 1'b0; m_udf = 1'b0;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs_stat(m) !== {4'd0, 5'b10000} || {o_key[m], o_val[m]} !== 32'h0) begin
        bad++; $display("FAIL async_rst[%0d] got stat=%b head=%h want %b/0", m, obs_stat(m),
                        {o_key[m], o_val[m]}, {4'd0, 5'b10000});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(16'd3, 16'h33);
    total++;
    if (obs_stat(0) !== exp_stat(0) || {o_key[0], o_val[0]} !== exp_head(0)) begin
      bad++; $display("FAIL post_rst got stat=%b head=%h want %b/%h", obs_stat(0), {o_key[0], o_val[0]},
                      exp_stat(0), exp_head(0));
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_min_first();
    test_flush();
    test_ties();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_array_pq_kv.md
Name: register_array_pq_kv

Overview:
- Parametrised successor to the team's single-cycle register-array priority queue.
- Stores key/value pairs, with an explicit per-entry valid bit instead of "zero means empty".
- Selectable max-first or min-first ordering, synchronous flush, occupancy count, and sticky overflow/underflow error flags.
- Sits in front of schedulers as a drop-in queue:
  - accepts one push, pop or replace per cycle;
  - presents the best entry at the head.

Parameters:
- QUEUE_SIZE, 8, number of entries; must be even and >= 4.
- KEY_WIDTH, 16, width of the priority key.
- VAL_WIDTH, 16, width of the payload carried with each key.
- MAX_FIRST, 1, 1: the largest key is at the head; 0: the smallest key is at the head.

Ports:
- i_CLK  input  1  clock, rising edge.
- i_RSTn  input  1  asynchronous active-low reset.
- i_wrt  input  1  push request.
- i_read  input  1  pop request.
- i_flush  input  1  synchronous clear of all entries.
- i_key  input  KEY_WIDTH  key of the pushed/replacing entry.
- i_val  input  VAL_WIDTH  payload of the pushed/replacing entry.
- i_clr_err  input  1  clears the sticky error flags.
- o_key  output  KEY_WIDTH  head key.
- o_val  output  VAL_WIDTH  head payload.
- o_valid  output  1  head entry is valid (equals !o_empty).
- o_full  output  1  size == QUEUE_SIZE.
- o_empty  output  1  size == 0.
- o_size  output  $clog2(QUEUE_SIZE)+1  number of valid entries.
- o_ovf  output  1  sticky: a push was dropped because the queue was full.
- o_udf  output  1  sticky: a pop was issued while the queue was empty.

Behaviour:
- Reset (async, i_RSTn low):
  - all entry valid bits, keys and values = 0;
  - size = 0; o_ovf = o_udf = 0;
  - outputs: o_key = 0, o_val = 0, o_valid = 0, o_empty = 1, o_full = 0.
- Operation decode, sampled at the rising edge; effects are visible on outputs the following cycle (latency 1).
  - Priority: i_flush > replace (i_wrt & i_read) > push (i_wrt only) > pop (i_read only) > idle.
- Flush:
  - all valid bits = 0, size = 0;
  - any concurrent push/pop is ignored;
  - error flags are unaffected.
- Push:
  - not full: the entry is inserted and size + 1;
  - full: the queue is unchanged and o_ovf is set.
- Pop:
  - not empty: the head is removed and size - 1;
  - empty: no change and o_udf is set.
- Replace:
  - not empty: the head is removed and the new entry inserted in the same cycle; size unchanged;
  - empty: behaves as a push, so size becomes 1;
  - never sets an error flag.
- Ordering:
  - Compare is unsigned on the key only.
  - Invalid entries rank below every valid entry in either mode.
  - Each cycle performs one compare-exchange stage pass over the array.
  - Invariant, required after every cycle: o_key/o_val are the best-ranked valid entry currently stored.
  - Full sortedness of the non-head positions is not required.
- Ties: equal keys have no order guarantee, but the key/value pairing must never be split.
- Empty head: when o_empty = 1, o_key = 0 and o_val = 0 (masked), regardless of stale register contents.
- Error flags:
  - set on the cycle after the offending request;
  - held until i_clr_err;
  - if i_clr_err and a new error coincide, the flag stays set.
- Size width: o_size must represent QUEUE_SIZE exactly; no wrap is possible because push-when-full and pop-when-empty are blocked.
- A zero key is a legal, storable value; occupancy derives only from the valid bits and the size counter.

Test Plan:
1. Reset, MAX_FIRST=1, QUEUE_SIZE=8:
   - push keys 5, 9, 0, 3 with values 0xA5, 0xA9, 0xA0, 0xA3 on consecutive cycles;
   - required: o_size=4; head 9/0xA9;
   - four pops then yield heads 9, 5, 3, 0 in order, then o_empty=1 and o_key=0.
2. Fill with 8 pushes (keys 1..8), then push key 100:
   - required: o_full=1, o_ovf=1, head=8, o_size=8;
   - pulse i_clr_err: required o_ovf=0.
3. Pop on an empty queue:
   - required: o_udf=1, o_size=0;
   - then push key 7: required o_valid=1, head=7, o_udf still 1.
4. Queue holds 4, 6, 2; replace with key 5:
   - required: head becomes 5, o_size=3;
   - then replace with key 1: required head 4;
   - then replace on an empty queue after a flush: required o_size=1, no error flag.
5. MAX_FIRST=0: push 30, 10, 20:
   - required: head 10; pops yield 10, 20, 30.
6. Push 3 entries, then assert i_flush together with i_wrt:
   - required next cycle: o_size=0, o_empty=1, o_key=0;
   - reset asserted mid-stream returns all outputs to reset values asynchronously.
